midi_cc_tx: RTL

MIDI_CC_TX -- requirements
Module: midi_cc_tx

---
 rtl/midi_cc_tx.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/midi_cc_tx.sv
// Button-to-MIDI Control Change transmitter: debounced edges become CC messages serialised at MIDI baud.
// Optional RUNNING_STATUS_EN macro drops repeated status bytes; queue drops events (sticky overflow) when full.
`timescale 1ns/1ps
module midi_cc_tx #(
    parameter int NUM_BTNS     = 4,
    parameter int BAUD_DIV     = 3200,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int CHANNEL      = 0,
    parameter int FIRST_CC     = 46,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] btn,
    output logic                midi_tx,
    output logic                busy,
    output logic [NUM_BTNS-1:0] led,
    output logic                overflow
);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam int BW = $clog2(BAUD_DIV + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [7:0]    STATUS    = {4'hB, 4'(CHANNEL)};
    localparam logic [6:0]    CC_BASE   = 7'(FIRST_CC);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

    logic [NUM_BTNS-1:0] sync1, sync2, deb, accept, pend, pval;
    logic [DW-1:0]       db_cnt [NUM_BTNS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    always_comb begin
        accept = '0;
        for (int i = 0; i < NUM_BTNS; i++)
            accept[i] = (sync2[i] != deb[i]) && (db_cnt[i] == DB_LAST);
    end

    // Counter runs only while the synchronised level disagrees; any agreement restarts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb <= '0;
            for (int i = 0; i < NUM_BTNS; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_BTNS; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (accept[i]) begin
                    db_cnt[i] <= '0;
                    deb[i]    <= sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    logic       sel_vld, sel_val;
    logic [3:0] sel_idx;

    always_comb begin
        sel_vld = 1'b0;
        sel_val = 1'b0;
        sel_idx = '0;
        for (int i = NUM_BTNS - 1; i >= 0; i--) begin
            if (pend[i]) begin
                sel_vld = 1'b1;
                sel_val = pval[i];
                sel_idx = 4'(i);
            end
        end
    end

    state_t        state;
    logic [10:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          pop, push, drop;
    logic [10:0]   fifo_q;

    assign pop    = (state == LOAD);
    assign push   = sel_vld && ((count != FULL_CNT) || pop);
    assign drop   = sel_vld && (count == FULL_CNT) && !pop;
    assign fifo_q = mem[rd_ptr];

    // A fresh edge wins over the clear of the same button's bit being enqueued this cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend     <= '0;
            pval     <= '0;
            overflow <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BTNS; i++) begin
                if (accept[i]) begin
                    pend[i] <= 1'b1;
                    pval[i] <= sync2[i];
                end else if (sel_vld && sel_idx == 4'(i)) begin
                    pend[i] <= 1'b0;
                end
            end
            if (drop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {sel_idx, sel_val ? 7'h7F : 7'h00};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    sh;
    logic [15:0]   rest;
    logic [1:0]    left;
    logic [7:0]    d1, d2;
`ifdef RUNNING_STATUS_EN
    logic          rs_vld;
`endif

    assign d1 = {1'b0, CC_BASE + {3'b000, fifo_q[10:7]}};
    assign d2 = {1'b0, fifo_q[6:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            midi_tx  <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            sh       <= '0;
            rest     <= '0;
            left     <= '0;
`ifdef RUNNING_STATUS_EN
            rs_vld   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    midi_tx <= 1'b1;
                    if (count != '0) state <= LOAD;
                end
                LOAD: begin
`ifdef RUNNING_STATUS_EN
                    // Status is fixed by CHANNEL, so "same as last sent" reduces to "any sent since reset".
                    if (rs_vld) begin
                        sh   <= d1;
                        rest <= {8'h00, d2};
                        left <= 2'd1;
                    end else begin
                        sh     <= STATUS;
                        rest   <= {d2, d1};
                        left   <= 2'd2;
                        rs_vld <= 1'b1;
                    end
`else
                    sh   <= STATUS;
                    rest <= {d2, d1};
                    left <= 2'd2;
`endif
                    state    <= START;
                    midi_tx  <= 1'b0;
                    baud_cnt <= '0;
                end
                START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        midi_tx  <= sh[0];
                        sh       <= sh >> 1;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            midi_tx <= 1'b1;
                            state   <= STOP;
                        end else begin
                            midi_tx <= sh[0];
                            sh      <= sh >> 1;
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                STOP: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (left != 2'd0) begin
                            sh      <= rest[7:0];
                            rest    <= rest >> 8;
                            left    <= left - 2'd1;
                            midi_tx <= 1'b0;
                            state   <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE) || (count != '0);
    assign led  = deb;
endmodule
